// File: rtl/onewire_pkg.sv
// Shared one-wire definitions: responder states, DS18B20 command codes, slot timing
// in microseconds and the fixed part of the scratchpad.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRES_WAIT,
        ST_PRES,
        ST_ROM_RX,
        ST_FUNC_RX,
        ST_TX
    } ow_state_t;

    localparam logic [7:0] SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CONVERT_T    = 8'h44;
    localparam logic [7:0] READ_SCRATCH = 8'hBE;

    localparam int RST_MIN   = 480;
    localparam int PRES_WAIT = 30;
    localparam int PRES_LEN  = 120;
    localparam int SAMPLE_AT = 30;
    localparam int TX0_LEN   = 45;
    localparam int TX_BITS   = 72;

    localparam logic [15:0] TEMP_POWERUP = 16'h0550;
    // Scratchpad bytes 2..7, byte 2 in the low octet.
    localparam logic [47:0] SCRATCH_FIXED = 48'h100C_FF7F_464B;

    function automatic logic [7:0] scratch_byte(input logic [3:0]  idx,
                                                input logic [15:0] temp,
                                                input logic [7:0]  crc);
        logic [7:0] b;
        case (idx)
            4'd0:                          b = temp[7:0];
            4'd1:                          b = temp[15:8];
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
            4'd7:                          b = SCRATCH_FIXED[{idx[2:0] - 3'd2, 3'b000} +: 8];
            default:                       b = crc;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1, reflected, init 0), one data bit per enable.
module onewire_crc8 (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;
    logic       w_fb;

    assign w_fb  = r_crc[0] ^ i_bit;
    assign o_crc = r_crc;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || i_clr) begin
            r_crc <= 8'h00;
        end else if (i_en) begin
            r_crc <= {w_fb, r_crc[7:5], r_crc[4] ^ w_fb, r_crc[3] ^ w_fb, r_crc[2:1]};
        end
    end

endmodule

// File: rtl/ds18b20_responder.sv
// DS18B20 emulation on an open-drain one-wire bus: presence, Skip-ROM, Convert-T and
// Read-Scratchpad, serving the temperature presented on temp_in.
module ds18b20_responder
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US = 12,
    parameter int CONV_US    = 750000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    inout  wire         one_wire,
    input  logic [15:0] temp_in,
    output logic        busy_out,
    output logic [7:0]  cmd_out,
    output logic        cmd_valid
);

    localparam int PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int CONV_W = $clog2(CONV_US + 1);

    logic [1:0]        r_sync;
    logic              r_bus_prev;
    logic [PRE_W-1:0]  r_tick_pre;
    logic [PRE_W-1:0]  r_fall_pre;
    logic [9:0]        r_fall_us;
    logic [7:0]        r_st_us;
    ow_state_t         r_state, w_state_next;
    logic              r_arm, r_slot, r_tx_drive;
    logic [6:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_busy;
    logic [CONV_W-1:0] r_conv_cnt;
    logic [15:0]       r_temp;
    logic [7:0]        r_cmd;
    logic              r_cmd_valid;

    logic       w_bus, w_fall, w_rise, w_tick, w_us_step, w_reset_det, w_drive;
    logic       w_rx_state, w_confirm, w_sample, w_byte_done, w_tx_slot, w_tx_last;
    logic       w_tx_bit, w_crc_en, w_crc_clr;
    logic [7:0] w_rx_byte, w_tx_byte, w_crc;

    assign w_bus       = r_sync[1];
    assign w_fall      = r_bus_prev & ~w_bus;
    assign w_rise      = ~r_bus_prev & w_bus;
    assign w_tick      = (r_tick_pre == PRE_W'(CLK_PER_US - 1));
    // r_fall_us measures whole microseconds since the last falling edge on its own
    // prescaler, so slot sample/release points are phase-locked to the master's edge.
    assign w_us_step   = (r_fall_pre == PRE_W'(CLK_PER_US - 1));
    assign w_reset_det = w_rise && (r_fall_us >= 10'(RST_MIN));
    assign w_drive     = (r_state == ST_PRES) || r_tx_drive;
    assign one_wire    = w_drive ? 1'b0 : 1'bz;

    assign w_rx_state  = (r_state == ST_ROM_RX) || (r_state == ST_FUNC_RX);
    // A slot only counts if the bus is still low one microsecond after the edge.
    assign w_confirm   = r_arm && w_us_step && (r_fall_us == 10'd0) && !w_bus;
    assign w_sample    = r_slot && w_us_step && (r_fall_us == 10'(SAMPLE_AT - 1));
    assign w_rx_byte   = {w_bus, r_shift[7:1]};
    assign w_byte_done = w_sample && w_rx_state && (r_bit_cnt[2:0] == 3'd7);

    assign w_tx_byte   = scratch_byte(r_bit_cnt[6:3], r_temp, w_crc);
    assign w_tx_bit    = w_tx_byte[r_bit_cnt[2:0]];
    assign w_tx_slot   = w_confirm && (r_state == ST_TX);
    assign w_tx_last   = w_tx_slot && (r_bit_cnt == 7'(TX_BITS - 1));
    assign w_crc_en    = w_tx_slot && (r_bit_cnt < 7'd64);
    assign w_crc_clr   = w_reset_det ||
                         (w_byte_done && (r_state == ST_FUNC_RX) && (w_rx_byte == READ_SCRATCH));

    assign busy_out  = r_busy;
    assign cmd_out   = r_cmd;
    assign cmd_valid = r_cmd_valid;

    onewire_crc8 u_crc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_clr    (w_crc_clr),
        .i_en     (w_crc_en),
        .i_bit    (w_tx_bit),
        .o_crc    (w_crc)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_reset_det) begin
            w_state_next = ST_PRES_WAIT;
        end else begin
            case (r_state)
                ST_PRES_WAIT: if (r_st_us >= 8'(PRES_WAIT)) w_state_next = ST_PRES;
                ST_PRES:      if (r_st_us >= 8'(PRES_LEN))  w_state_next = ST_ROM_RX;
                ST_ROM_RX:    if (w_byte_done)
                                  w_state_next = (w_rx_byte == SKIP_ROM) ? ST_FUNC_RX : ST_IDLE;
                ST_FUNC_RX:   if (w_byte_done)
                                  w_state_next = (w_rx_byte == READ_SCRATCH) ? ST_TX : ST_IDLE;
                ST_TX:        if (w_tx_last) w_state_next = ST_IDLE;
                default:      w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_sync      <= 2'b11;
            r_bus_prev  <= 1'b1;
            r_tick_pre  <= '0;
            r_fall_pre  <= '0;
            r_fall_us   <= '0;
            r_st_us     <= '0;
            r_arm       <= 1'b0;
            r_slot      <= 1'b0;
            r_tx_drive  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_conv_cnt  <= '0;
            r_temp      <= TEMP_POWERUP;
            r_cmd       <= 8'h00;
            r_cmd_valid <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], one_wire};
            r_bus_prev  <= w_bus;
            r_tick_pre  <= w_tick ? '0 : r_tick_pre + 1'b1;
            r_cmd_valid <= 1'b0;

            if (w_fall) begin
                r_fall_pre <= '0;
                r_fall_us  <= '0;
            end else if (w_us_step) begin
                r_fall_pre <= '0;
                if (r_fall_us != '1) r_fall_us <= r_fall_us + 1'b1;
            end else begin
                r_fall_pre <= r_fall_pre + 1'b1;
            end

            if (w_state_next != r_state)       r_st_us <= '0;
            else if (w_tick && r_st_us != '1)  r_st_us <= r_st_us + 1'b1;

            if (w_reset_det) begin
                r_arm      <= 1'b0;
                r_slot     <= 1'b0;
                r_tx_drive <= 1'b0;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
            end else begin
                if (w_fall && !w_drive && (w_rx_state || r_state == ST_TX)) r_arm <= 1'b1;
                else if (w_us_step && r_fall_us == 10'd0)                  r_arm <= 1'b0;

                if (w_confirm && w_rx_state) r_slot <= 1'b1;
                else if (w_sample)           r_slot <= 1'b0;

                if (w_sample && w_rx_state) begin
                    r_shift   <= w_rx_byte;
                    r_bit_cnt <= w_byte_done ? 7'd0 : r_bit_cnt + 1'b1;
                end

                if (w_tx_slot) begin
                    r_tx_drive <= !w_tx_bit;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else if (w_us_step && r_fall_us == 10'(TX0_LEN - 1)) begin
                    r_tx_drive <= 1'b0;
                end

                if (w_byte_done && r_state == ST_FUNC_RX) begin
                    r_cmd       <= w_rx_byte;
                    r_cmd_valid <= 1'b1;
                end
            end

            // A bus reset leaves a running conversion alone; a new Convert-T restarts it.
            if (w_byte_done && r_state == ST_FUNC_RX && w_rx_byte == CONVERT_T) begin
                r_busy     <= 1'b1;
                r_conv_cnt <= CONV_W'(CONV_US);
            end else if (r_busy && w_tick) begin
                if (r_conv_cnt <= CONV_W'(1)) begin
                    r_busy     <= 1'b0;
                    r_conv_cnt <= '0;
                    r_temp     <= temp_in;
                end else begin
                    r_conv_cnt <= r_conv_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ds18b20_responder.sv
// Bench for ds18b20_responder: a one-wire master drives reset/write/read slots while
// scoreboard monitors compare commands, read bytes and conversion lengths.
module tb_ds18b20_responder;

    localparam int CPU  = 4;
    localparam int CONV = 100;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        m_low   = 1'b0;
    logic [15:0] temp_in = 16'h0191;
    logic        busy;
    logic        cmd_valid;
    logic [7:0]  cmd;
    wire         ow;

    pullup (ow);
    assign ow = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ds18b20_responder #(.CLK_PER_US(CPU), .CONV_US(CONV)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .one_wire  (ow),
        .temp_in   (temp_in),
        .busy_out  (busy),
        .cmd_out   (cmd),
        .cmd_valid (cmd_valid)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_rd[$];
    int         exp_busy[$];
    logic [7:0] rd_byte;
    event       rd_ev;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [63:0] data);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            c = c ^ data[8*i +: 8];
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    task automatic bus_reset(input int len, input logic pres);
        m_low = 1'b1;
        wait_us(len);
        m_low = 1'b0;
        wait_us(25);  check("pres_25us", 16'(ow), 16'd1);
        wait_us(15);  check("pres_40us", 16'(ow), pres ? 16'd0 : 16'd1);
        wait_us(100); check("pres_140us", 16'(ow), pres ? 16'd0 : 16'd1);
        wait_us(20);  check("pres_160us", 16'(ow), 16'd1);
        wait_us(20);
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            if (b[i]) begin wait_us(6);  m_low = 1'b0; wait_us(60); end
            else      begin wait_us(60); m_low = 1'b0; wait_us(6);  end
        end
    endtask

    task automatic read_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            wait_us(2);
            m_low = 1'b0;
            wait_us(13);
            b[i] = ow;
            wait_us(52);
        end
        rd_byte = b;
        -> rd_ev;
    endtask

    initial begin : cmd_monitor
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cmd_unexpected: got %h, required no pulse", cmd);
                end else begin
                    check("cmd_out", 16'(cmd), 16'(exp_cmd.pop_front()));
                end
            end
        end
    end

    initial begin : rd_monitor
        forever begin
            @(rd_ev);
            if (exp_rd.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %h, required nothing", rd_byte);
            end else begin
                check("rd_byte", 16'(rd_byte), 16'(exp_rd.pop_front()));
            end
        end
    end

    initial begin : busy_monitor
        logic        prev;
        int unsigned cnt, t0, d;
        int          e;
        prev = 1'b0; cnt = 0; t0 = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (busy && !prev) t0 = cnt;
            if (!busy && prev) begin
                d = cnt - t0;
                total++;
                if (exp_busy.size() == 0) begin
                    bad++;
                    $display("FAIL busy_unexpected: got %0d cycles, required no conversion", d);
                end else begin
                    e = exp_busy.pop_front();
                    // e == 0 marks a conversion cut short by rst_n_in.
                    if ((e == 0) ? (d < CONV * CPU - CPU) : (d > e - CPU && d <= e))
                        $display("ok   busy_len: %0d cycles", d);
                    else begin
                        bad++;
                        $display("FAIL busy_len: got %0d cycles, required %0d (one tick window)", d, e);
                    end
                end
            end
            prev = busy;
        end
    end

    initial begin : stimulus
        logic [63:0] sp;
        repeat (5) @(negedge clk);
        check("rst_bus", 16'(ow), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_cmd", 16'(cmd), 16'h00);
        check("rst_cmd_valid", 16'(cmd_valid), 16'd0);
        rst_n = 1'b1;
        wait_us(10);

        bus_reset(500, 1'b1);
        bus_reset(300, 1'b0);

        // Read before any conversion, aborted by a reset after two bytes.
        bus_reset(500, 1'b1);
        write_byte(8'hCC);
        exp_cmd.push_back(8'hBE);
        write_byte(8'hBE);
        exp_rd.push_back(8'h50);
        exp_rd.push_back(8'h05);
        read_byte();
        read_byte();
        bus_reset(500, 1'b1);

        // Convert, then full scratchpad read.
        write_byte(8'hCC);
        exp_cmd.push_back(8'h44);
        exp_busy.push_back(CONV * CPU);
        write_byte(8'h44);
        check("busy_after_44", 16'(busy), 16'd1);
        wait_us(150);
        check("busy_done", 16'(busy), 16'd0);
        bus_reset(500, 1'b1);
        write_byte(8'hCC);
        exp_cmd.push_back(8'hBE);
        write_byte(8'hBE);
        sp = 64'h100C_FF7F_464B_0191;
        for (int i = 0; i < 8; i++) exp_rd.push_back(sp[8*i +: 8]);
        exp_rd.push_back(crc8(sp));
        for (int i = 0; i < 9; i++) read_byte();

        // Non-Skip ROM byte: silent until the next reset.
        bus_reset(500, 1'b1);
        write_byte(8'h33);
        exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'hFF);
        read_byte();
        read_byte();
        bus_reset(500, 1'b1);

        // rst_n_in during a conversion.
        write_byte(8'hCC);
        exp_cmd.push_back(8'h44);
        exp_busy.push_back(0);
        write_byte(8'h44);
        wait_us(20);
        check("busy_mid_conv", 16'(busy), 16'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk) #1;
        check("rstn_busy", 16'(busy), 16'd0);
        check("rstn_cmd", 16'(cmd), 16'h00);
        @(negedge clk) rst_n = 1'b1;
        wait_us(10);

        // rst_n_in in the middle of presence.
        m_low = 1'b1;
        wait_us(500);
        m_low = 1'b0;
        wait_us(80);
        check("pres_mid", 16'(ow), 16'd0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk) #1;
        check("rstn_release", 16'(ow), 16'd1);
        check("rstn_busy2", 16'(busy), 16'd0);
        check("rstn_cmd_valid", 16'(cmd_valid), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        wait_us(10);
        check("pres_after_rstn", 16'(ow), 16'd1);

        check("cmd_queue_left", 16'(exp_cmd.size()), 16'd0);
        check("rd_queue_left", 16'(exp_rd.size()), 16'd0);
        check("busy_queue_left", 16'(exp_busy.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ds18b20_responder.md
# ds18b20_responder

One-wire slave that emulates a DS18B20 temperature sensor on the `one_wire` bus, answering the board's one-wire master with presence, command reception, Convert-T and Read-Scratchpad. It sits on the FPGA side of the bus in place of a physical sensor, serving a temperature supplied on `temp_in`. This enables closed-loop simulation and sensor-less bring-up of the LED-screen temperature path.

## Interface
- `CLK_PER_US`, 12: `clk_in` cycles per microsecond; the prescaler produces a 1 µs tick.
- `CONV_US`, 750000: Convert-T duration in µs. Benches override this with a small value.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `one_wire`  inout  1  open-drain bus. The block only ever drives 0 or releases (z).
- `temp_in`  in  16  temperature in DS18B20 format (1/16 °C, two's complement). Sampled at conversion end.
- `busy_out`  out  1  high while a conversion runs.
- `cmd_out`  out  8  last accepted function command.
- `cmd_valid`  out  1  one-cycle pulse when `cmd_out` updates.

## Operation
- Bus input goes through a 2-FF synchronizer; falling and rising edges are detected on the synchronized value.
- A low-time counter in µs restarts on every falling edge.
- **Reset detect**: any low of ≥480 µs, seen at the rising edge, is a reset in any state. It aborts RX/TX, releases the bus and enters PRES_WAIT. A running conversion continues.
- **States**: IDLE → PRES_WAIT (30 µs) → PRES (drive 0 for 120 µs) → ROM_RX → FUNC_RX → TX or IDLE.
- **RX slot**: on a falling edge, sample the bus 30 µs later (1 = high, 0 = low). Bits are LSB first; 8 bits make a byte.
- **ROM_RX**:
  - 0xCC (Skip ROM) → FUNC_RX.
  - Any other byte → IDLE; the bus is ignored until the next reset.
- **FUNC_RX**:
  - Any completed byte updates `cmd_out` and pulses `cmd_valid`.
  - 0x44: `busy_out`=1 and the conversion timer starts, then → IDLE.
  - 0xBE: → TX, bit index 0.
  - Others: → IDLE.
- **Conversion**: after CONV_US ticks, copy `temp_in` into scratchpad bytes 0–1 and set `busy_out`=0.
  - 0x44 while busy restarts the timer.
- **Scratchpad**:
  - Bytes 0–1: temperature LSB/MSB. Power-up value 16'h0550 (+85 °C).
  - Bytes 2–7 are fixed: 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10.
  - Byte 8: Dallas CRC8 (x^8+x^5+x^4+1, init 0, LSB first) over bytes 0–7, accumulated serially as bits are sent.
- **TX slot**: on a falling edge, a 0 bit drives the bus low for 45 µs; a 1 bit leaves it released. Bits are LSB first, byte 0 first.
  - After 72 bits, → IDLE.
  - The master may stop early by issuing a reset.
- Read-Scratchpad during a conversion returns the previous temperature.

## Timing
- Reset values:
  - `one_wire` = z.
  - `busy_out` = 0.
  - `cmd_out` = 0x00.
  - `cmd_valid` = 0.
  - Scratchpad temperature = 0x0550.
  - State = IDLE.
  - CRC = 0.
  - Conversion timer cleared.
- All timing is in 1 µs ticks with ±1 µs tolerance. Edge detection latency is 2–3 `clk_in` cycles from the synchronizer.
- Presence is driven low 30–150 µs after the reset rising edge.
- The RX sample point is 30 µs after the falling edge; the TX 0-bit low window is 0–45 µs.
- A falling edge arriving while the block is still driving is ignored.
- `busy_out` falls exactly CONV_US ticks after the 8th bit of 0x44 is sampled. The scratchpad updates on the same cycle.
- Low pulses shorter than 1 µs do not start a slot (glitch reject).
- `rst_n_in` low mid-slot releases the bus on the next clock edge.

## Structure
- `onewire_pkg`: state enum, command constants (SKIP_ROM 0xCC, CONVERT_T 0x44, READ_SCRATCH 0xBE), µs constants (RST_MIN 480, PRES_WAIT 30, PRES_LEN 120, SAMPLE_AT 30, TX0_LEN 45), fixed scratchpad bytes.
- Sub-module `onewire_crc8`: serial CRC8 with clear/enable/bit inputs and 8-bit output, shared with future master-side CRC checking.

## Test plan
- 500 µs reset pulse → bus low from 30 to 150 µs after release; 300 µs pulse → no presence.
- Reset, 0xCC, 0x44 with CONV_US=100 and `temp_in`=0x0191 → `cmd_out`=0x44 with `cmd_valid` pulse; `busy_out` high for exactly 100 µs.
- Then reset, 0xCC, 0xBE, 9 read slots → bytes 0x91, 0x01, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, matching CRC8.
- 0xBE read before any conversion → bytes 0–1 = 0x50, 0x05.
- ROM byte 0x33 → no response to subsequent slots until reset; a reset after 2 read bytes aborts TX and returns presence.
- `rst_n_in` asserted mid-presence → bus released on the next clock; outputs at reset values; `busy_out`=0.
